// File: rtl/pc_pkg.sv
// pc_pkg: shared constants, command encoding and pointer-width helper for pc_stack
package pc_pkg;
  localparam int PC_WIDTH = 16;
  localparam int PC_DEPTH = 8;
  typedef enum logic [2:0] {CMD_HOLD, CMD_INC, CMD_LOAD, CMD_CALL, CMD_RET, CMD_CONFLICT} cmd_t;
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/lifo_mem.sv
// lifo_mem: DEPTH x WIDTH return-address storage, write at ptr, combinational read at ptr-1
module lifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   ptr,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  // store the pushed return address; contents need no reset
  always_ff @(posedge clk)
    if (we) mem[ptr] <= wdata;
  assign rdata = mem[ptr - ($clog2(DEPTH))'(1)];
endmodule

// File: rtl/pc_stack.sv
// pc_stack: program counter with return-address stack; PC_STACK_WRAP_EN makes the stack circular
module pc_stack
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = PC_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          in,
  input  logic                      load,
  input  logic                      inc,
  input  logic                      call,
  input  logic                      ret,
  output logic [WIDTH-1:0]          out,
  output logic [ptr_w(DEPTH)-1:0]   depth,
  output logic                      full,
  output logic                      empty,
  output logic                      overflow,
  output logic                      underflow,
  output logic                      conflict
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);
`ifdef PC_STACK_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  logic [AW-1:0] top;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] nxt;
  logic push;
  logic pop;
  cmd_t cmd;
  assign full = depth == PW'(DEPTH);
  assign empty = depth == '0;
  assign nxt = out + WIDTH'(1);
  // resolve simultaneous commands by fixed priority
  always_comb
    cmd = call && ret ? CMD_CONFLICT :
          ret         ? CMD_RET :
          call        ? CMD_CALL :
          load        ? CMD_LOAD :
          inc         ? CMD_INC : CMD_HOLD;
  assign push = cmd == CMD_CALL && (!full || WRAP);
  assign pop = cmd == CMD_RET && !empty;
  lifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk  (clk),
    .we   (push),
    .ptr  (top),
    .wdata(nxt),
    .rdata(tos)
  );
  // top wraps modulo DEPTH so a full circular push overwrites the oldest entry
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      out <= '0;
      depth <= '0;
      top <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
      conflict <= 1'b0;
    end else begin
      if (push) begin
        out <= in;
        top <= top + AW'(1);
        depth <= full ? depth : depth + PW'(1);
      end else if (pop) begin
        out <= tos;
        top <= top - AW'(1);
        depth <= depth - PW'(1);
      end else if (cmd == CMD_LOAD) out <= in;
      else if (cmd == CMD_INC) out <= nxt;
      overflow <= overflow | (cmd == CMD_CALL && full);
      underflow <= underflow | (cmd == CMD_RET && empty);
      conflict <= conflict | (cmd == CMD_CONFLICT);
    end
endmodule
